fixed_point_block_averager: RTL

FIXED_POINT_BLOCK_AVERAGER -- requirements
Module: fixed_point_block_averager

---
 rtl/fixed_point_block_averager_if.sv | 24 ++
 rtl/fixed_point_block_averager.sv | 90 +++++++++
 2 files changed

// File: rtl/fixed_point_block_averager_if.sv
// Sample stream in, block-mean stream out, for the fixed-point block averager.
// Master drives samples and consumes means; slave is the averager.
interface fixed_point_block_averager_if #(
   parameter int LOG2N = 4
);
   logic [25:0]      In_data;
   logic             In_valid;
   logic             In_ready;
   logic             Clear;
   logic [25:0]      Out_data;
   logic             Out_valid;
   logic             Out_ready;
   logic [LOG2N-1:0] Count;

   modport master (
      output In_data, In_valid, Clear, Out_ready,
      input  In_ready, Out_data, Out_valid, Count
   );

   modport slave (
      input  In_data, In_valid, Clear, Out_ready,
      output In_ready, Out_data, Out_valid, Count
   );
endinterface

// File: rtl/fixed_point_block_averager.sv
// Averages blocks of 2^LOG2N sfix26_En18 samples into one rounded mean.
// One pending mean is held until consumed; completion stalls behind it.
module fixed_point_block_averager #(
   parameter int LOG2N = 4
) (
   input logic clk,
   input logic GlobalReset,
   fixed_point_block_averager_if.slave bus
);

   localparam int AW = 26 + LOG2N;
   localparam logic [LOG2N-1:0] LAST = '1;
   localparam logic signed [AW-1:0] HALF =
      AW'(1) << (LOG2N - 1);

   typedef enum logic {ACCUM, PENDING} state_t;

   state_t state, state_nxt;

   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] sample;
   logic signed [AW-1:0] sum;
   logic signed [AW-1:0] rnd;
   logic [LOG2N-1:0]     count;
   logic [25:0]          out_data;
   logic [25:0]          mean;
   logic                 last;
   logic                 stall;
   logic                 transfer;
   logic                 complete;

   assign last  = (count == LAST);
   assign stall = last && (state == PENDING)
                  && !bus.Out_ready;

   assign bus.In_ready  = !bus.Clear && !stall;
   assign bus.Out_valid = (state == PENDING);
   assign bus.Out_data  = out_data;
   assign bus.Count     = count;

   assign transfer = bus.In_valid && bus.In_ready;
   assign complete = transfer && last;

   // Gate the sample so X on idle In_data never reaches the sum.
   assign sample = transfer
      ? {{LOG2N{bus.In_data[25]}}, bus.In_data}
      : '0;

   assign sum  = acc + sample;
   assign rnd  = sum + HALF;
   assign mean = 26'(rnd >>> LOG2N);

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: begin
            if (complete)
               state_nxt = PENDING;
         end
         PENDING: begin
            if (!complete && bus.Out_ready)
               state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge GlobalReset) begin
      if (!GlobalReset) begin
         state    <= ACCUM;
         acc      <= '0;
         count    <= '0;
         out_data <= '0;
      end else begin
         state <= state_nxt;
         if (bus.Clear) begin
            acc   <= '0;
            count <= '0;
         end else if (complete) begin
            acc      <= '0;
            count    <= '0;
            out_data <= mean;
         end else if (transfer) begin
            acc   <= sum;
            count <= count + 1'b1;
         end
      end
   end

endmodule
